// File: rtl/demux8_32_reg.sv
// demux8_32_reg: registered 1-to-8 distributor for WIDTH-bit words.
// Each lane holds one word with a valid flag and is released by its own ack.
// Drops to a held lane set a sticky overflow flag.
// Optional round-robin lane pointer: define DEMUX8_32_RR_EN.

// One output lane: data register plus valid flag with accept/reject decode.
module demux8_32_lane #(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_sel,     // write aimed at this lane this cycle
    input  logic             i_ack,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    output logic             o_accept,
    output logic             o_reject
);
    logic [WIDTH-1:0] r_data;
    logic             r_valid;

    // A held word can be replaced in the same cycle it is being consumed.
    assign o_accept = i_sel & (~r_valid | i_ack);
    assign o_reject = i_sel & r_valid & ~i_ack;
    assign o_data   = r_data;
    assign o_valid  = r_valid;

    // Lane data only changes on an accepted write; ack leaves data in place.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)         r_data <= RESET_VALUE;
        else if (o_accept) r_data <= i_data;
    end

    // Accepted write sets valid and beats a same-cycle ack; ack alone clears it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)         r_valid <= 1'b0;
        else if (o_accept) r_valid <= 1'b1;
        else if (i_ack)    r_valid <= 1'b0;
    end
endmodule

module demux8_32_reg #(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             s0,
    input  logic             s1,
    input  logic             s2,
    input  logic [WIDTH-1:0] in,
    input  logic             wren,
    input  logic [7:0]       ack,
    input  logic             auto,
    output logic [WIDTH-1:0] out0,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic [WIDTH-1:0] out3,
    output logic [WIDTH-1:0] out4,
    output logic [WIDTH-1:0] out5,
    output logic [WIDTH-1:0] out6,
    output logic [WIDTH-1:0] out7,
    output logic [7:0]       valid,
    output logic             full,
    output logic             overflow,
    input  logic             clr_ovf,
    output logic [2:0]       ptr
);
    logic [7:0][WIDTH-1:0] w_data;
    logic [7:0]            w_valid;
    logic [7:0]            w_acc;
    logic [7:0]            w_rej;
    logic [7:0]            w_sel;
    logic [2:0]            w_lane;
    logic                  r_ovf;

`ifdef DEMUX8_32_RR_EN
    logic [2:0] r_ptr;

    assign w_lane = auto ? r_ptr : {s2, s1, s0};
    assign ptr    = r_ptr;

    // Pointer advances only when an auto-targeted write actually lands.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)                 r_ptr <= 3'd0;
        else if (auto && |w_acc)   r_ptr <= r_ptr + 3'd1;
    end
`else
    logic w_unused_auto;

    assign w_unused_auto = auto;
    assign w_lane        = {s2, s1, s0};
    assign ptr           = 3'd0;
`endif

    // One-hot write strobe toward the target lane.
    always_comb begin
        w_sel         = '0;
        w_sel[w_lane] = wren;
    end

    for (genvar k = 0; k < 8; k++) begin : g_lane
        demux8_32_lane #(
            .WIDTH       (WIDTH),
            .RESET_VALUE (RESET_VALUE)
        ) u_lane (
            .clock    (clock),
            .reset    (reset),
            .i_sel    (w_sel[k]),
            .i_ack    (ack[k]),
            .i_data   (in),
            .o_data   (w_data[k]),
            .o_valid  (w_valid[k]),
            .o_accept (w_acc[k]),
            .o_reject (w_rej[k])
        );
    end

    // Sticky drop flag; a new rejection outranks a same-cycle clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)        r_ovf <= 1'b0;
        else if (|w_rej)  r_ovf <= 1'b1;
        else if (clr_ovf) r_ovf <= 1'b0;
    end

    assign out0     = w_data[0];
    assign out1     = w_data[1];
    assign out2     = w_data[2];
    assign out3     = w_data[3];
    assign out4     = w_data[4];
    assign out5     = w_data[5];
    assign out6     = w_data[6];
    assign out7     = w_data[7];
    assign valid    = w_valid;
    assign full     = &w_valid;
    assign overflow = r_ovf;
endmodule

// File: tb/tb_demux8_32_reg.sv
// Directed bench for demux8_32_reg: a spec-level model produces the expected
// lane/flag snapshot for each step, queued and compared after the clock edge.
module tb_demux8_32_reg;
    localparam logic [31:0] RV = 32'h5A5A_0001;
`ifdef DEMUX8_32_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    typedef struct {
        logic [7:0][31:0] out;
        logic [7:0]       valid;
        logic             ovf;
        logic             full;
        logic [2:0]       ptr;
    } snap_t;

    logic        clock = 1'b0;
    logic        reset, s0, s1, s2, wren, auto, clr_ovf;
    logic [31:0] d_in;
    logic [7:0]  ack;
    logic [31:0] out0, out1, out2, out3, out4, out5, out6, out7;
    logic [7:0]  valid;
    logic        full, overflow;
    logic [2:0]  ptr;

    int n_cmp  = 0;
    int n_fail = 0;

    snap_t            sb_q[$];
    logic [7:0][31:0] m_out;
    logic [7:0]       m_valid;
    logic             m_ovf;
    logic [2:0]       m_ptr;

    demux8_32_reg #(.WIDTH(32), .RESET_VALUE(RV)) dut (
        .clock(clock), .reset(reset), .s0(s0), .s1(s1), .s2(s2), .in(d_in),
        .wren(wren), .ack(ack), .auto(auto),
        .out0(out0), .out1(out1), .out2(out2), .out3(out3),
        .out4(out4), .out5(out5), .out6(out6), .out7(out7),
        .valid(valid), .full(full), .overflow(overflow), .clr_ovf(clr_ovf), .ptr(ptr)
    );

    always #5 clock = ~clock;

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 8; k++) m_out[k] = RV;
        m_valid = 8'h00;
        m_ovf   = 1'b0;
        m_ptr   = 3'd0;
    endtask

    task automatic push_model();
        snap_t e;
        e.out   = m_out;
        e.valid = m_valid;
        e.ovf   = m_ovf;
        e.full  = &m_valid;
        e.ptr   = m_ptr;
        sb_q.push_back(e);
    endtask

    task automatic check(input string tag);
        snap_t            e;
        logic [7:0][31:0] o;
        n_cmp++;
        assert (sb_q.size() > 0) else begin
            n_fail++;
            $error("FAIL %s.sb: observed empty queue expected entry", tag);
        end
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            o = {out7, out6, out5, out4, out3, out2, out1, out0};
            for (int k = 0; k < 8; k++) cmp($sformatf("%s.out%0d", tag, k), o[k], e.out[k]);
            cmp({tag, ".valid"},    {24'd0, valid},    {24'd0, e.valid});
            cmp({tag, ".full"},     {31'd0, full},     {31'd0, e.full});
            cmp({tag, ".overflow"}, {31'd0, overflow}, {31'd0, e.ovf});
            cmp({tag, ".ptr"},      {29'd0, ptr},      {29'd0, e.ptr});
        end
    endtask

    // Drive one cycle, advance the model by the spec rules, check after the edge.
    task automatic step(input bit wr, input bit au, input logic [2:0] sel,
                        input logic [31:0] d, input logic [7:0] ak, input bit clr,
                        input string tag);
        logic [2:0] ln;
        bit         acc, rej;
        wren = wr; auto = au; {s2, s1, s0} = sel; d_in = d; ack = ak; clr_ovf = clr;
        ln  = (RR && au) ? m_ptr : sel;
        acc = wr && (!m_valid[ln] || ak[ln]);
        rej = wr && m_valid[ln] && !ak[ln];
        m_valid = m_valid & ~ak;
        if (acc) begin
            m_valid[ln] = 1'b1;
            m_out[ln]   = d;
        end
        if (rej)      m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        if (RR && au && acc) m_ptr = m_ptr + 3'd1;
        push_model();
        @(posedge clock);
        #1;
        wren = 1'b0; auto = 1'b0; ack = 8'h00; clr_ovf = 1'b0;
        check(tag);
    endtask

    initial begin
        reset = 1'b1; wren = 1'b0; auto = 1'b0; clr_ovf = 1'b0;
        {s2, s1, s0} = 3'd0; d_in = 32'd0; ack = 8'h00;
        #1;
        model_reset();
        push_model();
        check("reset");
        @(negedge clock);
        reset = 1'b0;

        // Select decode and first write after reset.
        step(1, 0, 3'd5, 32'hDEADBEEF, 8'h00, 0, "sel5");
        // Drop to a held lane, then clear; then set-wins over clear.
        step(1, 0, 3'd5, 32'h0000_0001, 8'h00, 0, "ovf_set");
        step(0, 0, 3'd0, 32'h0,         8'h00, 1, "ovf_clr");
        step(1, 0, 3'd5, 32'h0000_0002, 8'h00, 1, "ovf_setwins");
        step(0, 0, 3'd0, 32'h0,         8'h00, 1, "ovf_clr2");
        // Write paired with ack on a held lane keeps valid and takes new data.
        step(1, 0, 3'd3, 32'h1111_2222, 8'h00, 0, "w3");
        step(1, 0, 3'd3, 32'hA5A5A5A5, 8'h08, 0, "w3_ack");
        // Ack on an empty lane does nothing; ack on held lane only clears it.
        step(0, 0, 3'd0, 32'h0, 8'h01, 0, "ack_empty");
        step(0, 0, 3'd0, 32'h0, 8'hFF, 0, "ack_all0");
        // auto is ignored without the pointer feature; with it, targets ptr.
        step(1, 1, 3'd4, 32'h0000_0444, 8'h00, 0, "auto_w");
        step(0, 0, 3'd0, 32'h0, 8'hFF, 0, "ack_all1");
        // Fill all lanes, then release them in one cycle.
        for (int k = 0; k < 8; k++) step(1, 0, 3'(k), 32'(k), 8'h00, 0, $sformatf("fill%0d", k));
        step(0, 0, 3'd0, 32'h0, 8'hFF, 0, "drain");
        // Back-to-back to one lane: second dropped without ack, kept with ack.
        step(1, 0, 3'd2, 32'h0000_0A01, 8'h00, 0, "b2b_a");
        step(1, 0, 3'd2, 32'h0000_0A02, 8'h00, 0, "b2b_drop");
        step(1, 0, 3'd2, 32'h0000_0A03, 8'h04, 0, "b2b_ack");
        // Mid-cycle asynchronous reset.
        step(1, 0, 3'd6, 32'h0000_0666, 8'h00, 0, "pre_rst6");
        #3;
        reset = 1'b1;
        #1;
        model_reset();
        push_model();
        check("rst_mid");
        #2;
        reset = 1'b0;
        step(1, 0, 3'd2, 32'h0000_0222, 8'h00, 0, "post_rst");
`ifdef DEMUX8_32_RR_EN
        step(0, 0, 3'd0, 32'h0, 8'hFF, 0, "rr_prep");
        for (int k = 0; k < 8; k++) step(1, 1, 3'd7, 32'(10 + k), 8'h00, 0, $sformatf("rr%0d", k));
        step(1, 1, 3'd7, 32'd18, 8'h01, 0, "rr_wrap");
        step(1, 1, 3'd7, 32'd99, 8'h00, 0, "rr_full");
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
